// File: rtl/color_clear_if.sv
// ----------------------------------------------------------------------------
// color_clear_if
// Purpose : Bundles the colour-register controller side (pass-through writes,
//           clear request) and the frame-buffer write port of the colour
//           clear engine into one interface.
// Ports   : in_addr/in_data/in_we     pass-through write from controller
//           clear_request/fill_data   clear pulse and fill byte
//           fb_grant                  frame buffer accepts the write this cycle
//           fb_addr/fb_data/fb_write_enable  registered frame-buffer write
//           clear_in_progress         controller write blocking
//           dropped_write             sticky lost-write flag
//           clear_done                only with COLOR_CLEAR_DONE_EN defined
// Modports: master = controller / frame-buffer side, slave = engine.
// ----------------------------------------------------------------------------
interface color_clear_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] in_addr;
    logic [7:0]        in_data;
    logic              in_we;
    logic              clear_request;
    logic [7:0]        fill_data;
    logic              fb_grant;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_data;
    logic              fb_write_enable;
    logic              clear_in_progress;
    logic              dropped_write;
`ifdef COLOR_CLEAR_DONE_EN
    logic              clear_done;
`endif

    modport master (
        output in_addr, in_data, in_we, clear_request, fill_data, fb_grant,
        input  fb_addr, fb_data, fb_write_enable, clear_in_progress, dropped_write
`ifdef COLOR_CLEAR_DONE_EN
        , input clear_done
`endif
    );

    modport slave (
        input  in_addr, in_data, in_we, clear_request, fill_data, fb_grant,
        output fb_addr, fb_data, fb_write_enable, clear_in_progress, dropped_write
`ifdef COLOR_CLEAR_DONE_EN
        , output clear_done
`endif
    );
endinterface

// File: rtl/color_clear_engine.sv
// ----------------------------------------------------------------------------
// color_clear_engine
// Purpose : Sits between the colour-register controller and the frame-buffer
//           A/B mux. Passes single-byte colour writes through with one cycle
//           of latency; on clear_request it owns the write port and fills
//           BASE_ADDR..BASE_ADDR+CELL_COUNT-1 with the latched fill byte, one
//           byte per granted cycle.
// Ports   : clk    clock
//           reset  synchronous, active-high reset
//           bus    color_clear_if.slave (see color_clear_if for signal list)
// Config  : COLOR_CLEAR_DONE_EN adds bus.clear_done, a registered one-cycle
//           pulse in the cycle clear_in_progress falls.
// ----------------------------------------------------------------------------
module color_clear_engine #(
    parameter int BASE_ADDR  = 8000,
    parameter int CELL_COUNT = 1000,
    parameter int ADDR_W     = 14
) (
    input  logic          clk,
    input  logic          reset,
    color_clear_if.slave  bus
);

    localparam int CNT_W = $clog2(CELL_COUNT + 1);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CELL_COUNT - 1);

    // The fill region must fit in the address space without wrapping.
    if (BASE_ADDR + CELL_COUNT - 1 > (2 ** ADDR_W) - 1) begin : g_range_err
        $error("color_clear_engine: colour region exceeds address space");
    end

    // PEND: clear accepted but a held pass-through write must complete first.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]        fb_data_q, fb_data_d;
    logic              fb_we_q, fb_we_d;
    logic              cip_q, cip_d;
    logic              dropped_q, dropped_d;
    logic [7:0]        fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              slot_free_s;
`ifdef COLOR_CLEAR_DONE_EN
    logic              done_q, done_d;
`endif

    // Output slot can take a new write if empty or being accepted this cycle.
    assign slot_free_s = !fb_we_q || bus.fb_grant;

    // Next-state and next-output computation.
    always_comb begin
        state_d   = state_q;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        fb_we_d   = fb_we_q;
        cip_d     = cip_q;
        dropped_d = dropped_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
`ifdef COLOR_CLEAR_DONE_EN
        done_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // Retire an accepted write; a stalled one keeps its contents.
                if (slot_free_s) begin
                    fb_we_d = 1'b0;
                end else begin
                    fb_we_d = fb_we_q;
                end
                if (bus.in_we) begin
                    if (slot_free_s) begin
                        fb_addr_d = bus.in_addr;
                        fb_data_d = bus.in_data;
                        fb_we_d   = 1'b1;
                    end else begin
                        dropped_d = 1'b1;
                    end
                end else begin
                    dropped_d = dropped_q;
                end
                if (bus.clear_request) begin
                    fill_d = bus.fill_data;
                    cnt_d  = {CNT_W{1'b0}};
                    cip_d  = 1'b1;
                    // Start straight away only if no write occupies the slot
                    // next cycle; otherwise wait for that write to complete.
                    if (slot_free_s && !bus.in_we) begin
                        state_d   = ST_CLEAR;
                        fb_addr_d = BASE_A;
                        fb_data_d = bus.fill_data;
                        fb_we_d   = 1'b1;
                    end else begin
                        state_d = ST_PEND;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (bus.in_we) begin
                    dropped_d = 1'b1;
                end else begin
                    dropped_d = dropped_q;
                end
                if (bus.fb_grant) begin
                    state_d   = ST_CLEAR;
                    fb_addr_d = BASE_A;
                    fb_data_d = fill_q;
                    fb_we_d   = 1'b1;
                    cnt_d     = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_PEND;
                end
            end
            ST_CLEAR: begin
                if (bus.in_we) begin
                    dropped_d = 1'b1;
                end else begin
                    dropped_d = dropped_q;
                end
                if (bus.fb_grant) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_IDLE;
                        fb_we_d = 1'b0;
                        cip_d   = 1'b0;
`ifdef COLOR_CLEAR_DONE_EN
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_d     = cnt_q + CNT_W'(1);
                        fb_addr_d = fb_addr_q + ADDR_W'(1);
                    end
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fb_we_d = 1'b0;
                cip_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            fb_addr_q <= {ADDR_W{1'b0}};
            fb_data_q <= 8'h00;
            fb_we_q   <= 1'b0;
            cip_q     <= 1'b0;
            dropped_q <= 1'b0;
            fill_q    <= 8'h00;
            cnt_q     <= {CNT_W{1'b0}};
`ifdef COLOR_CLEAR_DONE_EN
            done_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
            fb_we_q   <= fb_we_d;
            cip_q     <= cip_d;
            dropped_q <= dropped_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
`ifdef COLOR_CLEAR_DONE_EN
            done_q    <= done_d;
`endif
        end
    end

    assign bus.fb_addr           = fb_addr_q;
    assign bus.fb_data           = fb_data_q;
    assign bus.fb_write_enable   = fb_we_q;
    assign bus.clear_in_progress = cip_q;
    assign bus.dropped_write     = dropped_q;
`ifdef COLOR_CLEAR_DONE_EN
    assign bus.clear_done        = done_q;
`endif

endmodule

// File: tb/tb_color_clear_engine.sv
// ----------------------------------------------------------------------------
// tb_color_clear_engine
// Directed sequence with randomized data/addresses/grant patterns. Expected
// frame-buffer writes are queued in order and popped as writes complete.
// ----------------------------------------------------------------------------
module tb_color_clear_engine;

    localparam int BASE  = 8000;
    localparam int CELLS = 1000;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   gmode;
    int   cip_cycles;
    int   wr_count;
    int   done_pulses;
    logic [21:0] exp_q[$];

    color_clear_if #(.ADDR_W(14)) bus_if ();

    color_clear_engine #(
        .BASE_ADDR  (BASE),
        .CELL_COUNT (CELLS),
        .ADDR_W     (14)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe completed writes mid-cycle and compare against the expected order.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus_if.clear_in_progress === 1'b1) cip_cycles++;
`ifdef COLOR_CLEAR_DONE_EN
            if (bus_if.clear_done === 1'b1) done_pulses++;
`endif
            if (bus_if.fb_write_enable === 1'b1 && bus_if.fb_grant === 1'b1) begin
                wr_count++;
                checks++;
                assert (exp_q.size() > 0) else begin
                    failures++;
                    $error("FAIL unexpected_write observed=%0d/%0h expected=none",
                           bus_if.fb_addr, bus_if.fb_data);
                end
                if (exp_q.size() > 0) begin
                    logic [21:0] e;
                    e = exp_q.pop_front();
                    checks++;
                    assert ({bus_if.fb_addr, bus_if.fb_data} === e) else begin
                        failures++;
                        $error("FAIL write_seq observed=%0d/%0h expected=%0d/%0h",
                               bus_if.fb_addr, bus_if.fb_data, e[21:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        bus_if.in_we         = 1'b0;
        bus_if.clear_request = 1'b0;
        case (gmode)
            0:       bus_if.fb_grant = 1'b1;
            1:       bus_if.fb_grant = ~bus_if.fb_grant;
            2:       bus_if.fb_grant = 1'($urandom_range(0, 1));
            default: bus_if.fb_grant = 1'b0;
        endcase
    endtask

    task automatic push_fill(input logic [7:0] f);
        for (int i = 0; i < CELLS; i++) begin
            exp_q.push_back({14'(BASE + i), f});
        end
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (bus_if.clear_in_progress === 1'b1 && n < maxc) begin
            cyc();
            n++;
        end
        chk("clear_timeout", 32'(n < maxc), 32'd1);
    endtask

    task automatic start_clear(input logic [7:0] f);
        bus_if.fill_data     = f;
        bus_if.clear_request = 1'b1;
        push_fill(f);
    endtask

    initial begin
        logic [13:0] a;
        logic [7:0]  d;
        logic [7:0]  f;
        int          n;

        checks = 0; failures = 0; gmode = 0;
        cip_cycles = 0; wr_count = 0; done_pulses = 0;
        reset = 1'b1;
        bus_if.in_addr = 14'd0; bus_if.in_data = 8'h00; bus_if.in_we = 1'b0;
        bus_if.clear_request = 1'b0; bus_if.fill_data = 8'h00; bus_if.fb_grant = 1'b1;

        // Reset state
        repeat (3) cyc();
        chk("rst_addr", 32'(bus_if.fb_addr), 32'd0);
        chk("rst_data", 32'(bus_if.fb_data), 32'd0);
        chk("rst_we", 32'(bus_if.fb_write_enable), 32'd0);
        chk("rst_cip", 32'(bus_if.clear_in_progress), 32'd0);
        chk("rst_drop", 32'(bus_if.dropped_write), 32'd0);
        reset = 1'b0;
        cyc();

        // Pass-through, one cycle latency, one cycle wide
        bus_if.in_addr = 14'd8041; bus_if.in_data = 8'h3A; bus_if.in_we = 1'b1;
        exp_q.push_back({14'd8041, 8'h3A});
        cyc();
        chk("pt_we", 32'(bus_if.fb_write_enable), 32'd1);
        chk("pt_addr", 32'(bus_if.fb_addr), 32'd8041);
        chk("pt_data", 32'(bus_if.fb_data), 32'h3A);
        cyc();
        chk("pt_we_width", 32'(bus_if.fb_write_enable), 32'd0);

        // Random back-to-back pass-through writes
        for (int i = 0; i < 6; i++) begin
            a = 14'($urandom_range(0, 16383)); d = 8'($urandom);
            bus_if.in_addr = a; bus_if.in_data = d; bus_if.in_we = 1'b1;
            exp_q.push_back({a, d});
            cyc();
            chk("rpt_addr", 32'(bus_if.fb_addr), 32'(a));
            chk("rpt_data", 32'(bus_if.fb_data), 32'(d));
            chk("rpt_we", 32'(bus_if.fb_write_enable), 32'd1);
        end
        cyc();
        chk("rpt_drained", 32'(exp_q.size()), 32'd0);

        // Clear with grant tied high
        cip_cycles = 0; wr_count = 0; done_pulses = 0;
        start_clear(8'h5E);
        cyc();
        chk("clr_cip", 32'(bus_if.clear_in_progress), 32'd1);
        chk("clr_first_addr", 32'(bus_if.fb_addr), 32'(BASE));
        chk("clr_first_data", 32'(bus_if.fb_data), 32'h5E);
        wait_idle(3000);
        cyc();
        chk("clr_cip_cycles", 32'(cip_cycles), 32'(CELLS));
        chk("clr_writes", 32'(wr_count), 32'(CELLS));
        chk("clr_drained", 32'(exp_q.size()), 32'd0);
        chk("clr_we_off", 32'(bus_if.fb_write_enable), 32'd0);
`ifdef COLOR_CLEAR_DONE_EN
        chk("clr_done_pulses", 32'(done_pulses), 32'd1);
`endif

        // Clear with grant toggling, then with random grant
        for (int m = 1; m <= 2; m++) begin
            wr_count = 0;
            gmode = m;
            bus_if.fb_grant = 1'b1;
            f = 8'($urandom);
            start_clear(f);
            cyc();
            wait_idle(20000);
            cyc();
            chk("clr_stall_writes", 32'(wr_count), 32'(CELLS));
            chk("clr_stall_drained", 32'(exp_q.size()), 32'd0);
        end

        // Stall drop: held write survives, second write lost, flag sticky
        gmode = 3; bus_if.fb_grant = 1'b0;
        a = 14'($urandom_range(0, 7999)); d = 8'($urandom);
        bus_if.in_addr = a; bus_if.in_data = d; bus_if.in_we = 1'b1;
        exp_q.push_back({a, d});
        cyc();
        chk("stall_we", 32'(bus_if.fb_write_enable), 32'd1);
        bus_if.in_addr = 14'd123; bus_if.in_data = ~d; bus_if.in_we = 1'b1;
        cyc();
        chk("stall_drop", 32'(bus_if.dropped_write), 32'd1);
        chk("stall_hold_addr", 32'(bus_if.fb_addr), 32'(a));
        chk("stall_hold_data", 32'(bus_if.fb_data), 32'(d));
        repeat (3) cyc();
        gmode = 0; bus_if.fb_grant = 1'b1;
        cyc();
        cyc();
        chk("stall_drop_sticky", 32'(bus_if.dropped_write), 32'd1);
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // Clear requested while a write is held: write first, then fill
        gmode = 3; bus_if.fb_grant = 1'b0;
        a = 14'($urandom_range(0, 7999)); d = 8'($urandom);
        bus_if.in_addr = a; bus_if.in_data = d; bus_if.in_we = 1'b1;
        exp_q.push_back({a, d});
        cyc();
        f = 8'($urandom);
        start_clear(f);
        cyc();
        chk("pend_cip", 32'(bus_if.clear_in_progress), 32'd1);
        chk("pend_hold_addr", 32'(bus_if.fb_addr), 32'(a));
        cyc();
        gmode = 0; bus_if.fb_grant = 1'b1;
        cyc();
        chk("pend_start_addr", 32'(bus_if.fb_addr), 32'(BASE));
        wait_idle(3000);
        cyc();
        chk("pend_drained", 32'(exp_q.size()), 32'd0);

        // Same-cycle write and clear request
        f = 8'($urandom);
        bus_if.in_addr = 14'd8100; bus_if.in_data = 8'h11; bus_if.in_we = 1'b1;
        exp_q.push_back({14'd8100, 8'h11});
        start_clear(f);
        cyc();
        chk("same_addr", 32'(bus_if.fb_addr), 32'd8100);
        chk("same_data", 32'(bus_if.fb_data), 32'h11);
        chk("same_cip", 32'(bus_if.clear_in_progress), 32'd1);
        cyc();
        chk("same_fill_addr", 32'(bus_if.fb_addr), 32'(BASE));
        chk("same_fill_data", 32'(bus_if.fb_data), 32'(f));
        wait_idle(3000);
        cyc();
        chk("same_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-clear at 8500, then restart
        start_clear(8'($urandom));
        cyc();
        n = 0;
        while (bus_if.fb_addr !== 14'd8500 && n < 2000) begin
            cyc();
            n++;
        end
        chk("mid_reach_8500", 32'(bus_if.fb_addr), 32'd8500);
        reset = 1'b1;
        exp_q.delete();
        cyc();
        chk("mid_rst_addr", 32'(bus_if.fb_addr), 32'd0);
        chk("mid_rst_data", 32'(bus_if.fb_data), 32'd0);
        chk("mid_rst_we", 32'(bus_if.fb_write_enable), 32'd0);
        chk("mid_rst_cip", 32'(bus_if.clear_in_progress), 32'd0);
        chk("mid_rst_drop", 32'(bus_if.dropped_write), 32'd0);
        reset = 1'b0;
        f = 8'($urandom);
        start_clear(f);
        cyc();
        chk("restart_addr", 32'(bus_if.fb_addr), 32'(BASE));
        chk("restart_data", 32'(bus_if.fb_data), 32'(f));
        wait_idle(3000);
        cyc();
        chk("restart_drained", 32'(exp_q.size()), 32'd0);
        chk("restart_cip", 32'(bus_if.clear_in_progress), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
